load_store_unit: RTL and testbench

Memory-side responder for the decoder's Load/Store/mem_en outputs. Takes one load or store per request (fun3, effective address from the ALU, rs2 store data) and runs a word-aligned bus transaction with a req/ack handshake. It applies byte-lane enables and lane replication for stores, and lane extraction with sign/zero extension for loads. It stalls the core until the access completes or faults.

---
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Word-aligned memory bus between the load/store unit and memory.
// Request fields are held stable from req rise until ack.
interface load_store_unit_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [3:0]    be;
   logic [DW-1:0] wdata;
   logic          ack;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: lane steering, extension, req/ack bus access.
// Stalls the core from request until done or fault.
module load_store_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FUNCTION3  = 3,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic                  store_i,
   input  logic [FUNCTION3-1:0]  fun3_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  stall_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  fault_o,
   load_store_unit_if.master     bus
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE,
      FAULT
   } state_t;

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   state_t                state;
   logic [7:0]            cnt;
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [3:0]            be;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  done;
   logic                  fault;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            lo2;
   logic [2:0]            f3;

   logic                  ill;
   logic                  mis;
   logic [3:0]            nbe;
   logic [DATA_WIDTH-1:0] nwd;
   logic [7:0]            lb;
   logic [15:0]           lh;
   logic [DATA_WIDTH-1:0] ext;

   always_comb begin
      ill = 1'b0;
      mis = 1'b0;
      nbe = 4'hF;
      nwd = '0;
      if (load_i)
         ill = (fun3_i[2:0] == 3'b011) ||
               (fun3_i[2:1] == 2'b11);
      else
         ill = (fun3_i[2:0] > 3'b010);
      unique case (fun3_i[1:0])
         2'b00: begin
            nbe = 4'b0001 << addr_i[1:0];
            nwd = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            mis = addr_i[0];
            nbe = addr_i[1] ? 4'b1100 : 4'b0011;
            nwd = {2{wdata_i[15:0]}};
         end
         2'b10: begin
            mis = |addr_i[1:0];
            nbe = 4'hF;
            nwd = wdata_i;
         end
         default: begin
            nbe = 4'hF;
            nwd = wdata_i;
         end
      endcase
      if (load_i) begin
         nbe = 4'hF;
         nwd = '0;
      end
   end

   // Lane extraction uses the address captured at request time.
   always_comb begin
      lb  = bus.rdata[{lo2, 3'b000} +: 8];
      lh  = bus.rdata[{lo2[1], 4'b0000} +: 16];
      ext = bus.rdata;
      unique case (f3)
         3'b000:  ext = {{24{lb[7]}}, lb};
         3'b001:  ext = {{16{lh[15]}}, lh};
         3'b100:  ext = {24'b0, lb};
         3'b101:  ext = {16'b0, lh};
         default: ext = bus.rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         req   <= 1'b0;
         we    <= 1'b0;
         addr  <= '0;
         be    <= '0;
         wdata <= '0;
         done  <= 1'b0;
         fault <= 1'b0;
         rdata <= '0;
         lo2   <= '0;
         f3    <= '0;
      end else begin
         done  <= 1'b0;
         fault <= 1'b0;
         unique case (state)
            IDLE: begin
               if (load_i || store_i) begin
                  if (ill || mis) begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end else begin
                     state <= REQ;
                     req   <= 1'b1;
                     we    <= !load_i;
                     addr  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                     be    <= nbe;
                     wdata <= nwd;
                     lo2   <= addr_i[1:0];
                     f3    <= fun3_i[2:0];
                     cnt   <= '0;
                  end
               end
            end
            REQ: begin
               if (bus.ack) begin
                  state <= DONE;
                  req   <= 1'b0;
                  done  <= 1'b1;
                  if (!we)
                     rdata <= ext;
               end else if (cnt == LAST) begin
                  state <= FAULT;
                  req   <= 1'b0;
                  fault <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE:  state <= IDLE;
            FAULT: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Combinational so the requesting instruction freezes immediately.
   assign stall_o = !rst &&
                    (((state == IDLE) && (load_i || store_i)) ||
                     (state == REQ) || (state == FAULT));

   assign done_o    = done;
   assign fault_o   = fault;
   assign rdata_o   = rdata;
   assign bus.req   = req;
   assign bus.we    = we;
   assign bus.addr  = addr;
   assign bus.be    = be;
   assign bus.wdata = wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus random bench for load_store_unit against a
// reference model of lane, legality and latency rules.
module tb_load_store_unit;

   localparam int TO = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld;
   logic        st;
   logic [2:0]  f3;
   logic [31:0] a;
   logic [31:0] wd;
   logic        stall;
   logic        done;
   logic [31:0] rdata;
   logic        fault;

   int total = 0;
   int bad   = 0;
   logic [31:0] mrd = 32'h0;

   load_store_unit_if #(.AW(32), .DW(32)) bus ();

   load_store_unit #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .FUNCTION3(3),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .load_i(ld),
      .store_i(st),
      .fun3_i(f3),
      .addr_i(a),
      .wdata_i(wd),
      .stall_o(stall),
      .done_o(done),
      .rdata_o(rdata),
      .fault_o(fault),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mload(input logic [2:0] fn,
                                         input logic [31:0] ad,
                                         input logic [31:0] rd);
      logic [31:0] w;
      logic [31:0] v;
      w = rd >> (8 * (ad % 4));
      case (fn)
         3'd0: begin
            v = w % 256;
            if (v >= 128) v = v - 32'd256;
         end
         3'd1: begin
            v = w % 65536;
            if (v >= 32768) v = v - 32'd65536;
         end
         3'd4: v = w % 256;
         3'd5: v = w % 65536;
         default: v = rd;
      endcase
      return v;
   endfunction

   // Entered just after a falling edge; leaves just after one.
   task automatic run_op(input bit l, input bit s,
                         input logic [2:0] fn,
                         input logic [31:0] ad,
                         input logic [31:0] wv,
                         input int ackn,
                         input logic [31:0] rd);
      bit isl;
      bit legal;
      int sz;
      bit got;
      logic [31:0] ebe;
      logic [31:0] ewd;
      isl   = l;
      legal = isl ? (fn inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                  : (fn <= 3'd2);
      sz    = 1 << (fn % 4);
      if (legal && (ad % sz) != 0) legal = 0;
      ld = l; st = s; f3 = fn; a = ad; wd = wv;
      #1 chk("stall_req", 32'(stall), 32'd1);
      @(negedge clk);
      ld = 0; st = 0;
      #1;
      if (!legal) begin
         chk("fault", 32'(fault), 32'd1);
         chk("fault_noreq", 32'(bus.req), 32'd0);
         chk("fault_stall", 32'(stall), 32'd1);
         chk("fault_rdata", rdata, mrd);
         @(negedge clk); #1;
         chk("fault_end", 32'(fault), 32'd0);
         chk("fault_unstall", 32'(stall), 32'd0);
         return;
      end
      ebe = isl ? 32'hF : (((32'd1 << sz) - 1) << (ad % 4));
      ewd = (sz == 1) ? (wv % 256) * 32'h01010101 :
            (sz == 2) ? (wv % 65536) * 32'h00010001 : wv;
      got = 0;
      for (int k = 1; k <= TO && !got; k++) begin
         chk("req", 32'(bus.req), 32'd1);
         chk("we", 32'(bus.we), 32'(!isl));
         chk("addr", bus.addr, ad & ~32'd3);
         chk("be", 32'(bus.be), ebe);
         if (!isl) chk("wdata", bus.wdata, ewd);
         chk("req_stall", 32'(stall), 32'd1);
         chk("req_nodone", 32'(done), 32'd0);
         if (k == ackn) begin
            bus.ack = 1; bus.rdata = rd; got = 1;
         end
         @(negedge clk);
         bus.ack = 0;
         #1;
      end
      if (got) begin
         if (isl) mrd = mload(fn, ad, rd);
         chk("done", 32'(done), 32'd1);
         chk("done_stall", 32'(stall), 32'd0);
         chk("done_req", 32'(bus.req), 32'd0);
         chk("done_nofault", 32'(fault), 32'd0);
         chk("rdata", rdata, mrd);
      end else begin
         chk("tmo_fault", 32'(fault), 32'd1);
         chk("tmo_req", 32'(bus.req), 32'd0);
         chk("tmo_done", 32'(done), 32'd0);
         chk("tmo_rdata", rdata, mrd);
      end
      @(negedge clk); #1;
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);
   endtask

   initial begin
      rst = 1; ld = 0; st = 0; f3 = 0; a = 0; wd = 0;
      bus.ack = 0; bus.rdata = 0;
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_req", 32'(bus.req), 32'd0);
      @(negedge clk);
      rst = 0;
      #1;

      run_op(0, 1, 3'd0, 32'h1003, 32'hAB, 1, 0);
      run_op(1, 0, 3'd0, 32'h102, 0, 1, 32'h00800000);
      chk("lb_const", rdata, 32'hFFFFFF80);
      run_op(1, 0, 3'd4, 32'h102, 0, 1, 32'h00800000);
      chk("lbu_const", rdata, 32'h00000080);
      run_op(1, 0, 3'd1, 32'h100, 0, 1, 32'h1234F00D);
      chk("lh_const", rdata, 32'hFFFFF00D);
      run_op(1, 0, 3'd2, 32'h6, 0, 1, 0);
      run_op(1, 0, 3'd6, 32'h10, 0, 1, 0);
      run_op(0, 1, 3'd3, 32'h10, 32'h55, 1, 0);
      run_op(0, 1, 3'd1, 32'h2002, 32'hBEEF, 2, 0);
      run_op(0, 1, 3'd2, 32'h44, 32'hCAFEF00D, 5, 0);
      run_op(1, 0, 3'd2, 32'h40, 0, TO + 1, 0);
      run_op(1, 0, 3'd5, 32'h42, 0, TO, 32'h8765ABCD);
      run_op(1, 1, 3'd2, 32'h10, 32'h11, 1, 32'h0F0F1234);

      bus.ack = 1; bus.rdata = 32'hDEADBEEF;
      @(negedge clk); #1;
      bus.ack = 0;
      chk("unsol_done", 32'(done), 32'd0);
      chk("unsol_req", 32'(bus.req), 32'd0);
      chk("unsol_rdata", rdata, mrd);

      for (int i = 0; i < 60; i++) begin
         bit l;
         bit s;
         l = $urandom_range(0, 1);
         s = l ? bit'($urandom_range(0, 1)) : 1'b1;
         run_op(l, s, 3'($urandom_range(0, 7)),
                $urandom, $urandom,
                $urandom_range(1, TO + 1), $urandom);
      end

      ld = 1; st = 0; f3 = 3'd2; a = 32'h20;
      @(negedge clk);
      ld = 0;
      @(negedge clk);
      rst = 1;
      #1;
      mrd = 0;
      chk("mid_rst_req", 32'(bus.req), 32'd0);
      chk("mid_rst_stall", 32'(stall), 32'd0);
      chk("mid_rst_rdata", rdata, 32'd0);
      @(negedge clk);
      rst = 0;
      @(negedge clk); #1;
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_fault", 32'(fault), 32'd0);
      chk("post_rst_req", 32'(bus.req), 32'd0);

      run_op(1, 0, 3'd2, 32'h8, 0, 1, 32'hA5C3_0F81);
      chk("lw_const", rdata, 32'hA5C3_0F81);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
